// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-chained ripple adder split into STAGES chunks of
// WIDTH/STAGES bits. Each stage adds one chunk with the carry registered by
// the previous stage. Unconsumed operand bits travel forward with the
// transaction, and finished sum chunks travel with it too, so the full sum
// leaves the last stage in one piece.
//
// Handshake: the pipeline advances when adv = out_ready | ~out_valid.
// in_ready equals adv. An input transfers on an edge with in_valid & in_ready,
// and a result is consumed on an edge with out_valid & out_ready. While adv is
// low every stage register, valid bits included, holds its value.
//
// Optional feature: define PIPELINED_ADDER_SUB_EN to add a 'sub' input.
// When sub=1 the block computes a + ~b + 1, ignores cin, and cout is the
// not-borrow. The operand is inverted on entry, so the subtract selection
// travels with its transaction.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    // Per-stage registered state
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ovf_q;

    // Inputs seen by each stage, and the values each stage produces
    logic [STAGES-1:0] stg_v;
    logic [STAGES-1:0] stg_c;
    logic [WIDTH-1:0]  stg_a [STAGES];
    logic [WIDTH-1:0]  stg_b [STAGES];
    logic [WIDTH-1:0]  stg_s [STAGES];
    logic [CW:0]       nx_ext [STAGES];
    logic [WIDTH-1:0]  nx_s [STAGES];
    logic              nx_ovf;

    logic              adv;
    logic [WIDTH-1:0]  b_in;
    logic              c_in;

    assign adv       = out_ready | ~v_q[STAGES-1];
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Entry operand conditioning: subtraction becomes a + ~b + 1
    always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
        b_in = sub ? ~b : b;
        c_in = sub ? 1'b1 : cin;
`else
        b_in = b;
        c_in = cin;
`endif
    end

    // Stage input selection: stage 0 takes the ports, later stages take the
    // registers of the stage before them
    always_comb begin
        stg_v[0] = in_valid;
        stg_c[0] = c_in;
        stg_a[0] = a;
        stg_b[0] = b_in;
        stg_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_v[k] = v_q[k-1];
            stg_c[k] = c_q[k-1];
            stg_a[k] = a_q[k-1];
            stg_b[k] = b_q[k-1];
            stg_s[k] = s_q[k-1];
        end
    end

    // Chunk adders: stage k fills in sum bits [k*CW +: CW] and makes the
    // carry for stage k+1
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nx_ext[k] = {1'b0, stg_a[k][k*CW +: CW]}
                      + {1'b0, stg_b[k][k*CW +: CW]}
                      + {{CW{1'b0}}, stg_c[k]};
            nx_s[k] = stg_s[k];
            nx_s[k][k*CW +: CW] = nx_ext[k][CW-1:0];
        end
        // carry into MSB = a_msb ^ b_msb ^ sum_msb, so ovf is that XOR cout
        nx_ovf = stg_a[STAGES-1][WIDTH-1] ^ stg_b[STAGES-1][WIDTH-1]
               ^ nx_s[STAGES-1][WIDTH-1] ^ nx_ext[STAGES-1][CW];
    end

    // Stage registers: clear on reset, shift together when adv is high,
    // and hold everything otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= stg_v[k];
                c_q[k] <= nx_ext[k][CW];
                a_q[k] <= stg_a[k];
                b_q[k] <= stg_b[k];
                s_q[k] <= nx_s[k];
            end
            ovf_q <= nx_ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder (WIDTH=32, STAGES=4). Directed vectors feed
// an expected-result queue. A monitor on the falling edge pops and compares
// each result the DUT hands over.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] exp_e;
  int               chk_cnt = 0;
  int               pass_cnt = 0;
  int               run_len = 0;
  int               max_run = 0;

  // clock / reset
  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // driver: present one transaction, wait for acceptance, queue its result
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic tc, input logic ts,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    else exp_q.push_back({es, ec, eo});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // called just after the accepting edge of a lone transaction
  task automatic latency_check(input string name);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, 64'(lat), 64'(STAGES));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'({sum, cout, ovf}), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("result", 64'({sum, cout, ovf}), 64'(exp_e));
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // wrap-around and first-input latency
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    latency_check("latency_after_reset");
    drain("drain_wrap");

    // signed overflow, carry-in, chunk-boundary carries
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    send(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    drain("drain_vectors");

    // back-to-back burst: 10 consecutive valid cycles
    max_run = 0;
    for (int i = 0; i < 10; i++)
      send(32'(i), 32'(i), 1'b0, 1'b0, 32'(2 * i), 1'b0, 1'b0);
    drain("drain_burst");
    check("burst_run_length", 64'(max_run), 64'd10);

    // fill with out_ready low, hold, then release while accepting more
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_hold_sum", 64'(sum), 64'd3);
    end
    out_ready = 1'b1;
    send(32'd100, 32'd200, 1'b0, 1'b0, 32'h0000_012C, 1'b0, 1'b0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain("drain_stall");

    // reset with three transactions in flight
    send(32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0);
    send(32'd3, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("flushed_no_output", 64'(out_valid), 64'd0);
    end
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
    latency_check("latency_after_midrst");
    drain("drain_midrst");

`ifdef PIPELINED_ADDER_SUB_EN
    // subtraction: cin ignored, cout is not-borrow
    send(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send(32'd9, 32'd4, 1'b1, 1'b0, 32'd14, 1'b0, 1'b0);
    drain("drain_sub");
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages; WIDTH mod STAGES == 0, chunk width CW = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, cin valid this cycle.
REQ-006 SHALL have port in_ready  output  1  pipeline accepts input this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, unsigned or two's complement.
REQ-008 SHALL have port cin  input  1  carry into bit 0.
REQ-009 SHALL have port out_valid  output  1  sum, cout and ovf valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-011 SHALL have port sum  output  WIDTH  a+b+cin mod 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port ovf  output  1  signed overflow, i.e. carry into MSB XOR carry out of MSB.

Function
REQ-014 Stage k (0..STAGES-1) SHALL ripple-add operand bits [k*CW +: CW] with the carry registered from stage k-1; stage 0 SHALL use cin.
REQ-015 Operand chunks not yet consumed SHALL be skew-registered forward; completed sum chunks SHALL be de-skew-registered so that all WIDTH sum bits of one transaction emerge together.
REQ-016 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid with no stall; throughput SHALL be one transaction per cycle.
REQ-017 Pipeline advance signal adv = out_ready OR NOT out_valid; in_ready SHALL equal adv combinationally.
REQ-018 A transfer SHALL occur on a rising edge where in_valid AND in_ready; a result SHALL be consumed on an edge where out_valid AND out_ready.
REQ-019 When adv is 0, every stage register, valid bit included, SHALL hold; sum/cout/ovf SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-020 When adv is 1 and in_valid is 0, a bubble (valid=0) SHALL enter stage 0; bubbles SHALL propagate and never raise out_valid.
REQ-021 Order SHALL be preserved; no transaction SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-022 Simultaneous consume and accept on the same edge with a full pipeline SHALL be legal and lossless.
REQ-023 Wrap-around: all-ones + 1 SHALL give sum 0, cout 1; no saturation.
REQ-024 STAGES == 1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-025 Asserting rst SHALL immediately clear all stage valid bits; out_valid SHALL be 0 and sum, cout and ovf SHALL be 0.
REQ-026 In-flight transactions SHALL be discarded on reset mid-operation; in_ready SHALL be 1 during and after reset.
REQ-027 The first input accepted after rst deasserts SHALL appear after exactly STAGES cycles.

Configuration
REQ-028 Macro PIPELINED_ADDER_SUB_EN defined: SHALL add input sub (1 bit, registered with the transaction); when sub=1 the block SHALL compute a + ~b + 1, ignoring cin, and cout SHALL be the NOT-borrow.
REQ-029 Macro undefined: SHALL have no sub port and SHALL perform addition only, with identical latency and handshake.

Verification (WIDTH=32, STAGES=4)
REQ-030 a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> after 4 cycles sum=0x00000000, cout=1, ovf=0.
REQ-031 a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1; a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A.
REQ-032 10 back-to-back inputs a=i, b=i, i=0..9, out_ready=1 -> out_valid high for 10 consecutive cycles, sums 0,2,...,18 in order.
REQ-033 Fill with 4 transactions, out_ready=0 for 5 cycles -> in_ready=0 and outputs held; then out_ready=1 -> all 4 results emerge in order, none lost.
REQ-034 rst pulse with 3 transactions in flight -> out_valid=0 at once, none emerge; a new input then appears 4 cycles later.
REQ-035 With PIPELINED_ADDER_SUB_EN: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0; a=7, b=5 -> sum=2, cout=1.
